// File: rtl/filter_frame_ctrl_pkg.sv
// Shared types and constants for the masked 2D WOS filter frame controller.
package filter_frame_ctrl_pkg;

    localparam int unsigned WORD      = 8;
    localparam int unsigned MAX_N     = 25;
    localparam int unsigned MIN_N     = 3;
    localparam int unsigned DRAIN_CYC = 4;
    localparam int unsigned TIMEOUT   = 1023;
    localparam int unsigned CNT_W     = 2 * WORD;
    localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CFG     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_t;

    typedef struct packed {
        logic [WORD-1:0] h;
        logic [WORD-1:0] w;
        logic [WORD-1:0] n;
    } geom_t;

    // Odd kernel in range, non-empty frame, and the kernel half-width must fit past the last column.
    function automatic logic cfg_legal(input geom_t g);
        logic [WORD-1:0] w_max;
        w_max = {WORD{1'b1}} - (g.n >> 1);
        return g.n[0] && (g.n >= WORD'(MIN_N)) && (g.n <= WORD'(MAX_N)) &&
               (g.h != '0) && (g.w != '0) && (g.w <= w_max);
    endfunction

endpackage

// File: rtl/filter_frame_ctrl_if.sv
// Host/config, address-generator and RAM-arbitration signals of the frame controller.
interface filter_frame_ctrl_if;
    import filter_frame_ctrl_pkg::*;

    logic [WORD-1:0] cfg_h;
    logic [WORD-1:0] cfg_w;
    logic [WORD-1:0] cfg_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            start;
    logic            abort;
    logic            ah_run;
    logic [WORD-1:0] ah_h;
    logic [WORD-1:0] ah_w;
    logic [WORD-1:0] ah_n;
    logic            ah_w_en;
    logic            ah_newline;
    logic            host_req;
    logic            host_gnt;
    logic            mem_sel;
    logic            busy;
    logic            done;
    logic [1:0]      err;

    modport master (
        output cfg_h, cfg_w, cfg_n, cfg_valid, start, abort, ah_w_en, ah_newline, host_req,
        input  cfg_ready, ah_run, ah_h, ah_w, ah_n, host_gnt, mem_sel, busy, done, err
    );

    modport slave (
        input  cfg_h, cfg_w, cfg_n, cfg_valid, start, abort, ah_w_en, ah_newline, host_req,
        output cfg_ready, ah_run, ah_h, ah_w, ah_n, host_gnt, mem_sel, busy, done, err
    );

endinterface

// File: rtl/filter_frame_ctrl_frame_counter.sv
// Per-frame output-write, kernel-row and idle counters with last-write and timeout flags.
module filter_frame_ctrl_frame_counter
    import filter_frame_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             w_en,
    input  logic             newline,
    input  logic [CNT_W-1:0] target,
    output logic             last_c,
    output logic             timeout_c
);

    logic [CNT_W-1:0]  out_cnt;
    logic [WORD-1:0]   row_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt  <= '0;
            row_cnt  <= '0;
            idle_cnt <= '0;
        end else if (clear) begin
            out_cnt  <= '0;
            row_cnt  <= '0;
            idle_cnt <= '0;
        end else if (en) begin
            if (w_en) begin
                out_cnt  <= out_cnt + CNT_W'(1);
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (newline) begin
                row_cnt <= row_cnt + WORD'(1);
            end
        end
    end

    // Target is never zero because a legal config has h>=1 and w>=1.
    assign last_c    = en & w_en & (out_cnt == target - CNT_W'(1));
    assign timeout_c = en & (idle_cnt == IDLE_W'(TIMEOUT));

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame controller: validates geometry, runs the address generator for one frame,
// drains the sorter pipeline and arbitrates the shared image/result RAM.
module filter_frame_ctrl
    import filter_frame_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    filter_frame_ctrl_if.slave bus
);

    state_t             state;
    state_t             next_state;
    geom_t              geom;
    geom_t              cfg_in_c;
    err_t               err_q;
    logic               cfg_valid_flag;
    logic               cfg_ok_c;
    logic               go_c;
    logic               last_c;
    logic               timeout_c;
    logic [CNT_W-1:0]   target;
    logic [DRAIN_W-1:0] drain_cnt;

    assign cfg_in_c = {bus.cfg_h, bus.cfg_w, bus.cfg_n};
    assign cfg_ok_c = cfg_legal(cfg_in_c);
    // A start seen while the host holds the RAM is dropped, not queued.
    assign go_c     = (state == ST_IDLE) & bus.start & cfg_valid_flag & ~bus.host_gnt;

    filter_frame_ctrl_frame_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (go_c),
        .en        (state == ST_RUN),
        .w_en      (bus.ah_w_en),
        .newline   (bus.ah_newline),
        .target    (target),
        .last_c    (last_c),
        .timeout_c (timeout_c)
    );

    // Next-state decode; abort outranks a coincident final write or timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (go_c) next_state = ST_RUN;
            ST_RUN: begin
                if (bus.abort)      next_state = ST_IDLE;
                else if (last_c)    next_state = ST_DRAIN;
                else if (timeout_c) next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.abort)                                 next_state = ST_IDLE;
                else if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State, geometry, error and all outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            geom           <= '0;
            target         <= '0;
            cfg_valid_flag <= 1'b0;
            err_q          <= ERR_NONE;
            drain_cnt      <= '0;
            bus.cfg_ready  <= 1'b1;
            bus.ah_run     <= 1'b0;
            bus.mem_sel    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.host_gnt   <= 1'b0;
        end else begin
            state         <= next_state;
            drain_cnt     <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            bus.cfg_ready <= (next_state == ST_IDLE);
            bus.ah_run    <= (next_state == ST_RUN);
            bus.mem_sel   <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            bus.busy      <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            bus.done      <= (next_state == ST_DONE);
            bus.host_gnt  <= bus.host_req && (next_state == ST_IDLE);

            if ((state == ST_IDLE) && bus.cfg_valid) begin
                if (cfg_ok_c) begin
                    geom           <= cfg_in_c;
                    target         <= CNT_W'(bus.cfg_h) * CNT_W'(bus.cfg_w);
                    cfg_valid_flag <= 1'b1;
                    err_q          <= ERR_NONE;
                end else begin
                    cfg_valid_flag <= 1'b0;
                    err_q          <= ERR_CFG;
                end
            end else if (((state == ST_RUN) || (state == ST_DRAIN)) && bus.abort) begin
                err_q <= ERR_ABORT;
            end else if ((state == ST_RUN) && timeout_c && !last_c) begin
                err_q <= ERR_TIMEOUT;
            end
        end
    end

    assign bus.ah_h = geom.h;
    assign bus.ah_w = geom.w;
    assign bus.ah_n = geom.n;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench for filter_frame_ctrl with a simple address-generator model.
module tb_filter_frame_ctrl;
    import filter_frame_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   wr_limit = 64;
    int   emitted  = 0;
    int   phase    = 0;

    always #5 clk = ~clk;

    filter_frame_ctrl_if bus ();

    filter_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int h, input int w, input int n);
        tick();
        bus.cfg_h     = WORD'(h);
        bus.cfg_w     = WORD'(w);
        bus.cfg_n     = WORD'(n);
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    // Address-generator model: one write every 4 run cycles, a newline every 8 writes.
    initial begin
        bus.ah_w_en    = 1'b0;
        bus.ah_newline = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ah_w_en    = 1'b0;
            bus.ah_newline = 1'b0;
            if (!bus.ah_run) begin
                phase   = 0;
                emitted = 0;
            end else begin
                if (phase == 3 && emitted < wr_limit) begin
                    bus.ah_w_en = 1'b1;
                    emitted++;
                    bus.ah_newline = (emitted % 8 == 0);
                end
                phase = (phase + 1) % 4;
            end
        end
    end

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int hold_bad;
        int d0;

        bus.cfg_h = '0; bus.cfg_w = '0; bus.cfg_n = '0; bus.cfg_valid = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.host_req = 1'b0;

        // Reset values while rst is held low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_ah_run", bus.ah_run, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mem_sel", bus.mem_sel, 0);
        chk("rst_host_gnt", bus.host_gnt, 0);
        chk("rst_flag", dut.cfg_valid_flag, 0);
        chk("rst_ah_h", bus.ah_h, 0);
        rst = 1'b1;
        @(negedge clk);

        pulse_start();
        chk("start_no_cfg", bus.ah_run, 0);

        // Illegal configurations
        cfg(8, 8, 4);     chk("bad_n_even_err", bus.err, 1); chk("bad_n_even_flag", dut.cfg_valid_flag, 0);
        cfg(8, 8, 27);    chk("bad_n_big_err", bus.err, 1);
        cfg(0, 8, 3);     chk("bad_h0_err", bus.err, 1);
        cfg(8, 255, 3);   chk("bad_w255_err", bus.err, 1);
        cfg(8, 244, 25);  chk("bad_w244_n25_err", bus.err, 1);
        pulse_start();
        chk("bad_start_ignored", bus.ah_run, 0);
        chk("bad_geom_kept", bus.ah_h, 0);

        // Legal boundary configurations
        cfg(5, 243, 25);  chk("ok_w243_n25_err", bus.err, 0); chk("ok_w243_ah_w", bus.ah_w, 243);
        chk("ok_w243_ah_n", bus.ah_n, 25); chk("ok_flag", dut.cfg_valid_flag, 1);
        cfg(8, 254, 3);   chk("ok_w254_err", bus.err, 0);
        cfg(9, 9, 4);     chk("bad_again_err", bus.err, 1); chk("bad_again_keep_w", bus.ah_w, 254);
        chk("bad_again_flag", dut.cfg_valid_flag, 0);
        cfg(8, 8, 3);     chk("cfg88_err", bus.err, 0); chk("cfg88_h", bus.ah_h, 8);
        chk("cfg88_w", bus.ah_w, 8); chk("cfg88_n", bus.ah_n, 3);

        // Full 8x8 frame
        pulse_start();
        chk("run_ah_run", bus.ah_run, 1);
        chk("run_busy", bus.busy, 1);
        chk("run_mem_sel", bus.mem_sel, 1);
        chk("run_cfg_ready", bus.cfg_ready, 0);
        chk("run_out_cnt0", dut.u_cnt.out_cnt, 0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.ah_w_en && dut.u_cnt.out_cnt == 16'd63) begin found = 1; break; end
            @(negedge clk);
        end
        chk("last_write_seen", found, 1);
        @(negedge clk);
        chk("drain_ah_run", bus.ah_run, 0);
        chk("drain_busy", bus.busy, 1);
        chk("drain_mem_sel", bus.mem_sel, 1);
        chk("drain_out_cnt", dut.u_cnt.out_cnt, 64);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_no_done", bus.done, 0);
        end
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_mem_sel", bus.mem_sel, 0);
        chk("done_ah_run", bus.ah_run, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", 32'(dut.state), 32'(ST_IDLE));
        chk("frame_row_cnt", dut.u_cnt.row_cnt, 8);
        chk("frame_out_cnt", dut.u_cnt.out_cnt, 64);
        chk("frame_err", bus.err, 0);

        // Host held off during a frame
        pulse_start();
        repeat (10) @(negedge clk);
        tick();
        bus.host_req = 1'b1;
        hold_bad = 0;
        found    = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin found = 1; break; end
            if (bus.host_gnt || !bus.mem_sel) hold_bad++;
        end
        chk("host_frame_done", found, 1);
        chk("host_held_off", hold_bad, 0);
        chk("host_gnt_in_done", bus.host_gnt, 0);
        @(negedge clk);
        chk("host_gnt_after_done", bus.host_gnt, 1);
        chk("host_mem_sel_after_done", bus.mem_sel, 0);
        pulse_start();
        chk("start_blocked_by_host", bus.ah_run, 0);
        tick();
        bus.host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("host_gnt_released", bus.host_gnt, 0);

        // Abort mid-frame
        pulse_start();
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (dut.u_cnt.out_cnt == 16'd20) begin found = 1; break; end
            @(negedge clk);
        end
        chk("abort_reach_20", found, 1);
        d0 = done_cnt;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_ah_run", bus.ah_run, 0);
        chk("abort_err", bus.err, 3);
        chk("abort_busy", bus.busy, 0);
        chk("abort_mem_sel", bus.mem_sel, 0);
        chk("abort_state", 32'(dut.state), 32'(ST_IDLE));
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        pulse_start();
        chk("restart_ah_run", bus.ah_run, 1);
        chk("restart_out_cnt0", dut.u_cnt.out_cnt, 0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin found = 1; break; end
        end
        chk("restart_done", found, 1);
        chk("restart_out_cnt", dut.u_cnt.out_cnt, 64);

        // Timeout after 10 writes
        wr_limit = 10;
        pulse_start();
        d0 = done_cnt;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (dut.u_cnt.out_cnt == 16'd10) begin found = 1; break; end
            @(negedge clk);
        end
        chk("timeout_ten_writes", found, 1);
        repeat (1000) @(negedge clk);
        chk("timeout_not_early", bus.busy, 1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin found = 1; break; end
        end
        chk("timeout_expired", found, 1);
        chk("timeout_err", bus.err, 2);
        chk("timeout_state", 32'(dut.state), 32'(ST_IDLE));
        chk("timeout_ah_run", bus.ah_run, 0);
        repeat (5) @(negedge clk);
        chk("timeout_no_done", done_cnt, d0);
        wr_limit = 64;

        // Async reset during DRAIN
        pulse_start();
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (dut.state == ST_DRAIN) begin found = 1; break; end
            @(negedge clk);
        end
        chk("reach_drain", found, 1);
        chk("drain_err_before_rst", bus.err, 2);
        d0 = done_cnt;
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_ah_run", bus.ah_run, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_mem_sel", bus.mem_sel, 0);
        chk("mrst_err", bus.err, 0);
        chk("mrst_flag", dut.cfg_valid_flag, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_no_done", done_cnt, d0);
        chk("mrst_idle_ah_run", bus.ah_run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
